// File: rtl/twiddle_mul_s1.sv
// Twiddle multiplier between SDF butterfly stages 1 and 2 of a 32-point DIF FFT.
// Each sample is tagged with its frame index. Indices 0..15 pass through with
// W = 1. Indices 16..31 are multiplied by W32^(idx-16) = cos - j*sin.
// The pipeline has three stages: operand/coefficient register, product
// register, then round, saturate and output register.
module twiddle_mul_s1 #(
  parameter int DATA_W  = 12,
  parameter int TW_W    = 12,
  parameter int TW_FRAC = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_first,
  input  logic signed [DATA_W-1:0] in_real,
  input  logic signed [DATA_W-1:0] in_imag,
  output logic                     out_valid,
  output logic [4:0]               out_index,
  output logic signed [DATA_W-1:0] out_real,
  output logic signed [DATA_W-1:0] out_imag
);

  localparam int PW = DATA_W + TW_W;   // full product width
  localparam int SW = PW + 1;          // sum/difference width

  localparam logic signed [SW-1:0] RND    = SW'(2 ** (TW_FRAC - 1));
  localparam logic signed [SW-1:0] SAT_HI = SW'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_LO = SW'(-(2 ** (DATA_W - 1)));

  // Quarter-wave-plus coefficient tables, Q1.10: W32^k = COS[k] - j*SIN[k]
  localparam int COS_ROM [16] = '{1024, 1004, 946, 851, 724, 569, 392, 200,
                                  0, -200, -392, -569, -724, -851, -946, -1004};
  localparam int SIN_ROM [16] = '{0, 200, 392, 569, 724, 851, 946, 1004,
                                  1024, 1004, 946, 851, 724, 569, 392, 200};

  // Frame index counter
  logic [4:0] idx_reg, idx_next, sample_idx;

  // Stage A: operands, coefficient, index, valid
  logic signed [DATA_W-1:0] a_reg, b_reg;
  logic signed [TW_W-1:0]   c_reg, d_reg;
  logic signed [TW_W-1:0]   coef_c, coef_d;
  logic [4:0]               idx_a_reg;
  logic                     vld_a_reg;

  // Stage B: partial products
  logic signed [PW-1:0] ac_reg, bd_reg, ad_reg, bc_reg;
  logic [4:0]           idx_b_reg;
  logic                 vld_b_reg;

  // Stage C: output registers
  logic signed [DATA_W-1:0] out_real_reg, out_imag_reg;
  logic [4:0]               out_index_reg;
  logic                     out_valid_reg;

  // Combinational rounding of the complex product
  logic signed [SW-1:0] re_sum, im_sum, re_rnd, im_rnd, re_shr, im_shr;

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [SW-1:0] v);
    if (v > SAT_HI)
      sat = {1'b0, {(DATA_W-1){1'b1}}};
    else if (v < SAT_LO)
      sat = {1'b1, {(DATA_W-1){1'b0}}};
    else
      sat = v[DATA_W-1:0];
  endfunction

  // Index of the current sample (in_first forces a frame restart) and the
  // counter value for the following sample
  always_comb begin
    sample_idx = in_first ? 5'd0 : idx_reg;
    idx_next   = in_valid ? sample_idx + 5'd1 : idx_reg;
  end

  // Coefficient lookup: unity for the first half of the frame
  always_comb begin
    coef_c = TW_W'(2 ** TW_FRAC);
    coef_d = '0;
    if (sample_idx[4]) begin
      coef_c = TW_W'(COS_ROM[sample_idx[3:0]]);
      coef_d = TW_W'(-SIN_ROM[sample_idx[3:0]]);
    end
  end

  // Index counter advances only on accepted samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      idx_reg <= '0;
    else
      idx_reg <= idx_next;
  end

  // Stage A: capture operands and the selected coefficient
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      c_reg     <= '0;
      d_reg     <= '0;
      idx_a_reg <= '0;
      vld_a_reg <= 1'b0;
    end else begin
      a_reg     <= in_real;
      b_reg     <= in_imag;
      c_reg     <= coef_c;
      d_reg     <= coef_d;
      idx_a_reg <= sample_idx;
      vld_a_reg <= in_valid;
    end
  end

  // Stage B: four signed partial products
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ac_reg    <= '0;
      bd_reg    <= '0;
      ad_reg    <= '0;
      bc_reg    <= '0;
      idx_b_reg <= '0;
      vld_b_reg <= 1'b0;
    end else begin
      ac_reg    <= PW'(a_reg) * PW'(c_reg);
      bd_reg    <= PW'(b_reg) * PW'(d_reg);
      ad_reg    <= PW'(a_reg) * PW'(d_reg);
      bc_reg    <= PW'(b_reg) * PW'(c_reg);
      idx_b_reg <= idx_a_reg;
      vld_b_reg <= vld_a_reg;
    end
  end

  // Combine products, round half up, drop the fractional bits
  always_comb begin
    re_sum = SW'(ac_reg) - SW'(bd_reg);
    im_sum = SW'(ad_reg) + SW'(bc_reg);
    re_rnd = re_sum + RND;
    im_rnd = im_sum + RND;
    re_shr = re_rnd >>> TW_FRAC;
    im_shr = im_rnd >>> TW_FRAC;
  end

  // Stage C: saturated outputs; data holds across bubbles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_real_reg  <= '0;
      out_imag_reg  <= '0;
      out_index_reg <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= vld_b_reg;
      if (vld_b_reg) begin
        out_real_reg  <= sat(re_shr);
        out_imag_reg  <= sat(im_shr);
        out_index_reg <= idx_b_reg;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_index = out_index_reg;
  assign out_real  = out_real_reg;
  assign out_imag  = out_imag_reg;

endmodule

// File: tb/tb_twiddle_mul_s1.sv
// Directed bench for twiddle_mul_s1: inputs driven and outputs sampled on the
// falling edge; expected values are hand-computed Q1.10 products.
module tb_twiddle_mul_s1;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_first;
  logic signed [11:0] in_real, in_imag;
  logic              out_valid;
  logic [4:0]        out_index;
  logic signed [11:0] out_real, out_imag;

  int checks = 0;
  int errors = 0;

  twiddle_mul_s1 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .in_real   (in_real),
    .in_imag   (in_imag),
    .out_valid (out_valid),
    .out_index (out_index),
    .out_real  (out_real),
    .out_imag  (out_imag)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic f, input int r, input int i);
    @(negedge clk);
    in_valid = v;
    in_first = f;
    in_real  = 12'(r);
    in_imag  = 12'(i);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_real = '0; in_imag = '0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0d exp 0", out_valid); end
    checks++; if (out_index !== 5'd0) begin errors++; $display("FAIL reset_index got %0d exp 0", out_index); end
    checks++; if (out_real !== 0) begin errors++; $display("FAIL reset_real got %0d exp 0", out_real); end
    checks++; if (out_imag !== 0) begin errors++; $display("FAIL reset_imag got %0d exp 0", out_imag); end
    rst = 1'b0;
  endtask

  // 32-sample frame of (100, 50); results checked 3 cycles after each input
  task automatic test_stream();
    for (int t = 0; t < 36; t++) begin
      @(negedge clk);
      if (t >= 3) begin
        automatic int p = t - 3;
        if (p < 32) begin
          $display("txn stream idx=%0d re=%0d im=%0d", out_index, out_real, out_imag);
          checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid p=%0d got %0d exp 1", p, out_valid); end
          checks++; if (out_index !== 5'(p)) begin errors++; $display("FAIL stream_index got %0d exp %0d", out_index, p); end
          if (p <= 16) begin
            checks++; if (out_real !== 100 || out_imag !== 50) begin errors++; $display("FAIL stream_unity p=%0d got (%0d,%0d) exp (100,50)", p, out_real, out_imag); end
          end
          if (p == 20) begin
            checks++; if (out_real !== 106 || out_imag !== -35) begin errors++; $display("FAIL stream_k4 got (%0d,%0d) exp (106,-35)", out_real, out_imag); end
          end
          if (p == 24) begin
            checks++; if (out_real !== 50 || out_imag !== -100) begin errors++; $display("FAIL stream_minus_j got (%0d,%0d) exp (50,-100)", out_real, out_imag); end
          end
        end else begin
          checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_tail_valid got %0d exp 0", out_valid); end
          checks++; if (out_real !== -88 || out_imag !== -69 || out_index !== 5'd31) begin
            errors++; $display("FAIL stream_hold got (%0d,%0d) idx %0d exp (-88,-69) idx 31", out_real, out_imag, out_index);
          end
        end
      end
      in_valid = (t < 32);
      in_first = (t == 0);
      in_real  = 12'sd100;
      in_imag  = 12'sd50;
    end
  endtask

  // (1000, 0) at idx 20 -> (707, -707), exactly three cycles later
  task automatic test_rotation();
    drive(1'b1, 1'b1, 0, 0);
    for (int j = 1; j < 20; j++) drive(1'b1, 1'b0, 0, 0);
    drive(1'b1, 1'b0, 1000, 0);
    idle();
    idle();
    checks++; if (out_index !== 5'd19) begin errors++; $display("FAIL rot_early_index got %0d exp 19", out_index); end
    idle();
    $display("txn rotation idx=%0d re=%0d im=%0d", out_index, out_real, out_imag);
    checks++; if (out_valid !== 1'b1 || out_index !== 5'd20) begin errors++; $display("FAIL rot_tag got v%0d idx %0d exp v1 idx 20", out_valid, out_index); end
    checks++; if (out_real !== 707 || out_imag !== -707) begin errors++; $display("FAIL rot_data got (%0d,%0d) exp (707,-707)", out_real, out_imag); end
  endtask

  task automatic test_saturation();
    drive(1'b1, 1'b1, -2048, -2048);
    idle(); idle(); idle();
    $display("txn sat_neg idx=%0d re=%0d im=%0d", out_index, out_real, out_imag);
    checks++; if (out_valid !== 1'b1 || out_real !== -2048 || out_imag !== -2048) begin
      errors++; $display("FAIL sat_neg got v%0d (%0d,%0d) exp v1 (-2048,-2048)", out_valid, out_real, out_imag);
    end
    for (int j = 1; j < 18; j++) drive(1'b1, 1'b0, 0, 0);
    drive(1'b1, 1'b0, 2047, 2047);
    idle(); idle(); idle();
    $display("txn sat_pos idx=%0d re=%0d im=%0d", out_index, out_real, out_imag);
    checks++; if (out_index !== 5'd18) begin errors++; $display("FAIL sat_pos_index got %0d exp 18", out_index); end
    checks++; if (out_real !== 2047 || out_imag !== 1107) begin errors++; $display("FAIL sat_pos got (%0d,%0d) exp (2047,1107)", out_real, out_imag); end
  endtask

  task automatic test_gaps();
    automatic logic pv [5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    automatic int   er [5]  = '{10, 10, 20, 30, 30};
    automatic int   eidx [5] = '{0, 0, 1, 2, 2};
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (t >= 3) begin
        automatic int p = t - 3;
        $display("txn gaps v=%0d idx=%0d re=%0d im=%0d", out_valid, out_index, out_real, out_imag);
        checks++; if (out_valid !== pv[p]) begin errors++; $display("FAIL gap_valid p=%0d got %0d exp %0d", p, out_valid, pv[p]); end
        checks++; if (out_real !== er[p] || out_imag !== -er[p] || out_index !== 5'(eidx[p])) begin
          errors++; $display("FAIL gap_data p=%0d got (%0d,%0d) idx %0d exp (%0d,%0d) idx %0d",
                             p, out_real, out_imag, out_index, er[p], -er[p], eidx[p]);
        end
      end
      if (t < 5) begin
        in_valid = pv[t];
        in_first = (t == 0);
        in_real  = 12'(er[t]);
        in_imag  = 12'(-er[t]);
      end else begin
        in_valid = 1'b0;
        in_first = 1'b0;
      end
    end
  endtask

  // Counter is at 3 on entry; advance to 9, then resynchronise
  task automatic test_resync();
    for (int j = 0; j < 6; j++) drive(1'b1, 1'b0, 0, 0);
    drive(1'b1, 1'b1, 300, -200);
    drive(1'b1, 1'b0, 5, 6);
    idle(); idle();
    $display("txn resync idx=%0d re=%0d im=%0d", out_index, out_real, out_imag);
    checks++; if (out_valid !== 1'b1 || out_index !== 5'd0) begin errors++; $display("FAIL resync_first got v%0d idx %0d exp v1 idx 0", out_valid, out_index); end
    checks++; if (out_real !== 300 || out_imag !== -200) begin errors++; $display("FAIL resync_first_data got (%0d,%0d) exp (300,-200)", out_real, out_imag); end
    idle();
    $display("txn resync idx=%0d re=%0d im=%0d", out_index, out_real, out_imag);
    checks++; if (out_valid !== 1'b1 || out_index !== 5'd1) begin errors++; $display("FAIL resync_next got v%0d idx %0d exp v1 idx 1", out_valid, out_index); end
    checks++; if (out_real !== 5 || out_imag !== 6) begin errors++; $display("FAIL resync_next_data got (%0d,%0d) exp (5,6)", out_real, out_imag); end
  endtask

  task automatic test_reset_midflight();
    drive(1'b1, 1'b0, 7, 7);
    drive(1'b1, 1'b0, 7, 7);
    drive(1'b1, 1'b0, 7, 7);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midflight_pre got %0d exp 1", out_valid); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midflight_valid got %0d exp 0", out_valid); end
    checks++; if (out_real !== 0 || out_imag !== 0 || out_index !== 5'd0) begin
      errors++; $display("FAIL midflight_clear got (%0d,%0d) idx %0d exp (0,0) idx 0", out_real, out_imag, out_index);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b0, 40, 41);
    idle(); idle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midflight_flushed got %0d exp 0", out_valid); end
    idle();
    $display("txn after_reset idx=%0d re=%0d im=%0d", out_index, out_real, out_imag);
    checks++; if (out_valid !== 1'b1 || out_index !== 5'd0) begin errors++; $display("FAIL after_reset_tag got v%0d idx %0d exp v1 idx 0", out_valid, out_index); end
    checks++; if (out_real !== 40 || out_imag !== 41) begin errors++; $display("FAIL after_reset_data got (%0d,%0d) exp (40,41)", out_real, out_imag); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_rotation();
    test_saturation();
    test_gaps();
    test_resync();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
